ram_block_mover: RTL and testbench



---
 rtl/ram_block_mover.sv | 136 +++++++++++++
 tb/tb_ram_block_mover.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// Block FILL / forward COPY engine that owns the 64x32 data RAM port while busy.
// One command per start pulse; COPY alternates a read cycle and a write cycle per word.
module ram_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data
);

  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(1 << (ADDR_W - 2));
  localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_src_ptr;
  logic [ADDR_W-1:0]  r_dst_ptr;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   r_words_done;
  logic [DATA_W-1:0]  r_fill;
  logic [DATA_W-1:0]  r_buf;
  logic               r_err;
  logic               w_last;
  logic               w_unused;

  // Byte-lane bits of the command addresses are deliberately discarded.
  assign w_unused = ^{src_addr[1:0], dst_addr[1:0]};

  assign w_last     = (r_remaining == ONE);
  assign busy       = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_FILL);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign words_done = r_words_done;

  always_comb begin
    w_state_next = r_state;
    Mem_Write    = 1'b0;
    Mem_Addr     = '0;
    M_W_Data     = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len > MAX_LEN)
            w_state_next = S_IDLE;
          else if (len == '0)
            w_state_next = S_DONE;
          else
            w_state_next = mode ? S_RD : S_FILL;
        end
      end
      S_FILL: begin
        Mem_Write = 1'b1;
        Mem_Addr  = r_dst_ptr;
        M_W_Data  = r_fill;
        if (w_last)
          w_state_next = S_DONE;
      end
      S_RD: begin
        Mem_Addr     = r_src_ptr;
        w_state_next = S_WR;
      end
      S_WR: begin
        Mem_Write    = 1'b1;
        Mem_Addr     = r_dst_ptr;
        M_W_Data     = r_buf;
        w_state_next = w_last ? S_DONE : S_RD;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_fill       <= '0;
      r_buf        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_ptr    <= {src_addr[ADDR_W-1:2], 2'b00};
            r_dst_ptr    <= {dst_addr[ADDR_W-1:2], 2'b00};
            r_remaining  <= len;
            r_fill       <= fill_data;
            r_words_done <= '0;
            r_err        <= (len > MAX_LEN);
          end
        end
        // Pointer arithmetic is modulo the address width, so 0xFC + 4 wraps to 0x00.
        S_FILL, S_WR: begin
          r_dst_ptr    <= r_dst_ptr + WORD_INC;
          r_words_done <= r_words_done + ONE;
          r_remaining  <= r_remaining - ONE;
        end
        S_RD: begin
          r_buf     <= M_R_Data;
          r_src_ptr <= r_src_ptr + WORD_INC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Randomized bench for ram_block_mover: behavioural RAM plus a word-level model of
// each command (expected write list, final RAM image, latency).
module tb_ram_block_mover;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [7:0]  src_addr, dst_addr;
  logic [6:0]  len;
  logic [31:0] fill_data;
  logic        busy, done, err;
  logic [6:0]  words_done;
  logic        Mem_Write;
  logic [7:0]  Mem_Addr;
  logic [31:0] M_W_Data, M_R_Data;

  logic [31:0] ram   [64];
  logic [31:0] model [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_block_mover dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .M_W_Data(M_W_Data), .M_R_Data(M_R_Data)
  );

  always @(posedge clk) begin
    if (Mem_Write)
      ram[Mem_Addr[7:2]] <= M_W_Data;
    else if (pre_we)
      ram[pre_addr] <= pre_data;
  end
  assign M_R_Data = ram[Mem_Addr[7:2]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic write_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 6'(idx);
    pre_data = val;
    model[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload_random();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 6'(i);
      pre_data = $urandom;
      model[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // rst_after >= 0: pulse reset once that many words have been presented for writing.
  task automatic run_cmd(input string tag, input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [6:0] n, input logic [31:0] f, input int rst_after,
                         input logic glitch);
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    int nw, exp_lat, exp_busy, limit, rst_cycle;
    int done_at, done_cnt, busy_cnt, err_cnt, err_at, bad_align, mism;
    int di, si;
    logic [31:0] v;

    nw = (n > 64) ? 0 : int'(n);
    if (rst_after >= 0) nw = rst_after;
    for (int i = 0; i < nw; i++) begin
      di = (int'(d[7:2]) + i) % 64;
      si = (int'(s[7:2]) + i) % 64;
      v  = m ? model[si] : f;
      model[di] = v;
      exp_addr.push_back(8'(di * 4));
      exp_data.push_back(v);
    end
    if (rst_after >= 0 || n > 64) exp_lat = -1;
    else                          exp_lat = m ? 2 * int'(n) + 1 : int'(n) + 1;
    if (n > 64)              exp_busy = 0;
    else if (rst_after >= 0) exp_busy = 2 * rst_after;
    else                     exp_busy = m ? 2 * int'(n) : int'(n);
    limit = (exp_lat > 0) ? exp_lat + 3 : 40;

    done_at = -1; err_at = -1; rst_cycle = -1;
    done_cnt = 0; busy_cnt = 0; err_cnt = 0; bad_align = 0;

    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (Mem_Write) begin
        obs_addr.push_back(Mem_Addr);
        obs_data.push_back(M_W_Data);
      end
      if (Mem_Addr[1:0] != 2'b00) bad_align++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (err) begin
        err_cnt++;
        if (err_at < 0) err_at = cyc;
      end
      if (glitch && cyc == 2) begin
        start = 1'b1; mode = ~m; dst_addr = ~d; len = 7'd1; fill_data = ~f;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (rst_after >= 0 && rst_cycle < 0 && obs_addr.size() == rst_after) begin
        rst = 1'b1;
        rst_cycle = cyc;
      end
      if (rst_cycle > 0 && cyc == rst_cycle + 2) rst = 1'b0;
    end

    check_eq({tag, " done_at"},  done_at,  exp_lat);
    check_eq({tag, " done_cnt"}, done_cnt, (exp_lat > 0) ? 1 : 0);
    check_eq({tag, " busy_cnt"}, busy_cnt, exp_busy);
    check_eq({tag, " err_cnt"},  err_cnt,  (n > 64) ? 1 : 0);
    if (n > 64) check_eq({tag, " err_at"}, err_at, 1);
    check_eq({tag, " align"},    bad_align, 0);
    check_eq({tag, " n_writes"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check_eq({tag, $sformatf(" wr%0d_addr", i)}, obs_addr[i], exp_addr[i]);
      check_eq({tag, $sformatf(" wr%0d_data", i)}, obs_data[i], exp_data[i]);
    end
    check_eq({tag, " words_done"}, words_done, (rst_after >= 0) ? 0 : nw);
    mism = 0;
    for (int i = 0; i < 64; i++)
      if (ram[i] !== model[i]) mism++;
    check_eq({tag, " ram_mismatch_words"}, mism, 0);
    $display("[TB] %s mode=%0d src=0x%02h dst=0x%02h len=%0d writes=%0d done_at=%0d",
             tag, m, s, d, n, obs_addr.size(), done_at);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst busy",       busy,       0);
    check_eq("rst done",       done,       0);
    check_eq("rst err",        err,        0);
    check_eq("rst words_done", words_done, 0);
    check_eq("rst mem_write",  Mem_Write,  0);
    check_eq("rst mem_addr",   Mem_Addr,   0);
    check_eq("rst w_data",     M_W_Data,   0);
    rst = 1'b0;

    preload_random();
    run_cmd("fill4",   1'b0, 8'h00, 8'h10, 7'd4,  32'hDEADBEEF, -1, 1'b0);
    write_word(0, 32'h11111111);
    write_word(1, 32'h22222222);
    write_word(2, 32'h33333333);
    run_cmd("copy3",   1'b1, 8'h00, 8'h40, 7'd3,  32'h0,        -1, 1'b0);
    run_cmd("wrap",    1'b0, 8'h00, 8'hFE, 7'd2,  32'hA5A5A5A5, -1, 1'b0);
    run_cmd("len0",    1'b0, 8'h00, 8'h20, 7'd0,  32'h12345678, -1, 1'b0);
    run_cmd("len65",   1'b1, 8'h00, 8'h20, 7'd65, 32'h12345678, -1, 1'b0);
    run_cmd("fill64",  1'b0, 8'h00, 8'h00, 7'd64, 32'hCAFEF00D, -1, 1'b0);
    preload_random();
    run_cmd("rst_mid", 1'b1, 8'h00, 8'h80, 7'd8,  32'h0,         3, 1'b0);
    run_cmd("ign_fill",1'b0, 8'h00, 8'h30, 7'd5,  32'h0BADF00D, -1, 1'b1);
    run_cmd("ign_copy",1'b1, 8'h04, 8'h08, 7'd6,  32'h0,        -1, 1'b1);
    run_cmd("overlap", 1'b1, 8'hF8, 8'hFD, 7'd10, 32'h0,        -1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      logic        rm;
      logic [7:0]  rs, rd;
      logic [6:0]  rn;
      logic [31:0] rf;
      rm = 1'($urandom);
      rs = 8'($urandom);
      rd = 8'($urandom);
      rn = 7'($urandom_range(0, 66));
      rf = $urandom;
      run_cmd($sformatf("rand%0d", t), rm, rs, rd, rn, rf, -1, (rn >= 7'd2) ? 1'($urandom) : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
